pc_redirect_ctrl: RTL and testbench

- Sequencing controller for the 32-bit program counter.
- Arbitrates redirect requests from decode (jump, taken branch, skip), stall requests from the hazard unit and halt. It converts them into the PC's control inputs: sync reset, branch with offset, branchN (+2), jmp with target.
- Implements stall as "branch by 0", since the PC has no enable.
- Generates the flush/bubble window after a taken redirect and a fetch-valid qualifier for the fetch stage.

---
 rtl/pc_redirect_ctrl.sv | 150 +++++++++++++++
 tb/tb_pc_redirect_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/pc_redirect_ctrl.sv
// pc_redirect_ctrl: sequencing controller for the program counter.
// Turns decode redirects (jump, taken branch, skip), hazard stalls and halt
// into the PC's control strobes. The PC has no enable, so a hold is issued
// as "branch by 0". Controls are combinational so a redirect takes effect
// on the same rising edge the PC samples them.
// Optional build macro PCCTL_REDIRECT_CNT_EN adds a saturating 16-bit count
// of accepted jump/branch redirects on output redirect_cnt.
module pc_redirect_ctrl #(
   parameter int ADDR_W       = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     stall,
   input  logic                     halt_req,
   input  logic                     jmp_req,
   input  logic [ADDR_W-1:0]        jmp_tgt,
   input  logic                     br_req,
   input  logic signed [ADDR_W-1:0] br_off,
   input  logic                     skip_req,
   output logic                     pc_rst,
   output logic                     pc_branch,
   output logic signed [ADDR_W-1:0] pc_immval,
   output logic                     pc_branchN,
   output logic                     pc_jmp,
   output logic [ADDR_W-1:0]        pc_jumpim,
   output logic                     flush,
   output logic                     fetch_valid,
`ifdef PCCTL_REDIRECT_CNT_EN
   output logic [15:0]              redirect_cnt,
`endif
   output logic [1:0]               state_dbg
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      HALT  = 2'd3
   } state_t;

   // Counter preload leaves FLUSH_CYCLES bubble cycles before fetch resumes.
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

   state_t     state, state_nxt;
   logic [2:0] cnt, cnt_nxt;
   logic       redirect_acc;

   assign state_dbg = state;

   // State and bubble counter registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= BOOT;
         cnt   <= 3'd0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Request arbitration, next state and PC control strobes.
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      redirect_acc = 1'b0;
      pc_rst       = 1'b0;
      pc_branch    = 1'b0;
      pc_immval    = '0;
      pc_branchN   = 1'b0;
      pc_jmp       = 1'b0;
      pc_jumpim    = '0;
      flush        = 1'b0;
      fetch_valid  = 1'b0;
      case (state)
         BOOT: begin
            pc_rst    = 1'b1;
            state_nxt = RUN;
         end
         RUN: begin
            // A stall arriving with a redirect is dropped; the hazard unit
            // re-asserts it on the new path if still needed.
            if (halt_req) begin
               pc_branch = 1'b1;
               flush     = 1'b1;
               state_nxt = HALT;
            end else if (jmp_req) begin
               pc_jmp       = 1'b1;
               pc_jumpim    = jmp_tgt;
               flush        = 1'b1;
               redirect_acc = 1'b1;
               if (FLUSH_CYCLES != 0) begin
                  state_nxt = FLUSH;
                  cnt_nxt   = FLUSH_LOAD;
               end
            end else if (br_req) begin
               pc_branch    = 1'b1;
               pc_immval    = br_off;
               flush        = 1'b1;
               redirect_acc = 1'b1;
               if (FLUSH_CYCLES != 0) begin
                  state_nxt = FLUSH;
                  cnt_nxt   = FLUSH_LOAD;
               end
            end else if (skip_req) begin
               pc_branchN  = 1'b1;
               fetch_valid = 1'b1;
            end else if (stall) begin
               pc_branch = 1'b1;
            end else begin
               fetch_valid = 1'b1;
            end
         end
         FLUSH: begin
            // Redirects seen here are wrong-path and are ignored.
            flush = 1'b1;
            if (halt_req) begin
               pc_branch = 1'b1;
               state_nxt = HALT;
               cnt_nxt   = 3'd0;
            end else begin
               pc_branch = stall;
               if (cnt == 3'd0) begin
                  state_nxt = RUN;
               end else begin
                  cnt_nxt = cnt - 3'd1;
               end
            end
         end
         HALT: begin
            pc_branch = 1'b1;
         end
         default: begin
            state_nxt = BOOT;
         end
      endcase
   end

`ifdef PCCTL_REDIRECT_CNT_EN
   // Saturating count of accepted jump and taken-branch redirects.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         redirect_cnt <= 16'd0;
      end else if (redirect_acc && (redirect_cnt != 16'hFFFF)) begin
         redirect_cnt <= redirect_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// Testbench for pc_redirect_ctrl: directed scenarios plus random requests,
// with expected control vectors queued at drive time and compared when sampled.
module tb_pc_redirect_ctrl;
   localparam int ADDR_W = 32;
   localparam int FC     = 2;

   logic              clock = 1'b0;
   logic              reset = 1'b1;
   logic              stall = 1'b0, halt_req = 1'b0, jmp_req = 1'b0;
   logic              br_req = 1'b0, skip_req = 1'b0;
   logic [ADDR_W-1:0] jmp_tgt = '0, br_off = '0;
   logic              pc_rst, pc_branch, pc_branchN, pc_jmp, flush, fetch_valid;
   logic [ADDR_W-1:0] pc_immval, pc_jumpim;
   logic [1:0]        state_dbg;
`ifdef PCCTL_REDIRECT_CNT_EN
   logic [15:0]       redirect_cnt;
   logic [15:0]       cnt_q[$];
   int                m_cnt = 0;
`endif

   always #5 clock = ~clock;

   pc_redirect_ctrl #(.ADDR_W(ADDR_W), .FLUSH_CYCLES(FC)) dut (
      .clock(clock), .reset(reset), .stall(stall), .halt_req(halt_req),
      .jmp_req(jmp_req), .jmp_tgt(jmp_tgt), .br_req(br_req), .br_off(br_off),
      .skip_req(skip_req), .pc_rst(pc_rst), .pc_branch(pc_branch),
      .pc_immval(pc_immval), .pc_branchN(pc_branchN), .pc_jmp(pc_jmp),
      .pc_jumpim(pc_jumpim), .flush(flush), .fetch_valid(fetch_valid),
`ifdef PCCTL_REDIRECT_CNT_EN
      .redirect_cnt(redirect_cnt),
`endif
      .state_dbg(state_dbg)
   );

   wire [71:0] got_vec = {pc_rst, pc_branch, pc_immval, pc_branchN, pc_jmp,
                          pc_jumpim, flush, fetch_valid, state_dbg};
   localparam logic [71:0] RST_VEC = {1'b1, 71'd0};

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [71:0] exp_q[$];
   int         m_state = 0;   // 0 boot, 1 run, 2 flush, 3 halt
   int         m_left  = 0;   // bubble cycles still owed

   task automatic check_eq(input string tag, input logic [71:0] got, input logic [71:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at posedge+1: drives a request set, queues the expected outputs,
   // compares at negedge and advances the model at the next posedge.
   task automatic step(input string tag, input logic s, input logic h, input logic j,
                       input logic [31:0] t, input logic b, input logic [31:0] o,
                       input logic k);
      logic rst_e, br_e, bn_e, j_e, fl_e, fv_e, acc;
      logic [31:0] imm_e, tg_e;
      int ns, nl;
      stall = s; halt_req = h; jmp_req = j; jmp_tgt = t;
      br_req = b; br_off = o; skip_req = k;
      rst_e = 0; br_e = 0; bn_e = 0; j_e = 0; fl_e = 0; fv_e = 0; acc = 0;
      imm_e = 0; tg_e = 0; ns = m_state; nl = m_left;
      if (m_state == 0) begin
         rst_e = 1; ns = 1;
      end else if (m_state == 3) begin
         br_e = 1;
      end else if (h) begin
         br_e = 1; fl_e = 1; ns = 3;
      end else if (m_state == 2) begin
         fl_e = 1; br_e = s; nl = m_left - 1;
         if (nl == 0) ns = 1;
      end else if (j || b) begin
         fl_e = 1; acc = 1;
         if (j) begin j_e = 1; tg_e = t; end
         else begin br_e = 1; imm_e = o; end
         if (FC > 0) begin ns = 2; nl = FC; end
      end else if (k) begin
         bn_e = 1; fv_e = 1;
      end else if (s) begin
         br_e = 1;
      end else begin
         fv_e = 1;
      end
      exp_q.push_back({rst_e, br_e, imm_e, bn_e, j_e, tg_e, fl_e, fv_e, 2'(m_state)});
`ifdef PCCTL_REDIRECT_CNT_EN
      cnt_q.push_back(16'(m_cnt));
      if (acc && m_cnt < 65535) m_cnt++;
`endif
      @(negedge clock);
      check_eq(tag, got_vec, exp_q.pop_front());
`ifdef PCCTL_REDIRECT_CNT_EN
      check_eq({tag, "_cnt"}, {56'd0, redirect_cnt}, {56'd0, cnt_q.pop_front()});
`endif
      @(posedge clock);
      m_state = ns; m_left = nl;
      #1;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 0, 0, 0, 0, 0, 0, 0);
   endtask

   // Asynchronous reset: outputs must switch before any clock edge.
   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      check_eq(tag, got_vec, RST_VEC);
      m_state = 0; m_left = 0;
`ifdef PCCTL_REDIRECT_CNT_EN
      m_cnt = 0;
      check_eq({tag, "_cnt"}, {56'd0, redirect_cnt}, 72'd0);
`endif
      @(posedge clock);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      #2;
      do_reset("reset_init");
      step("boot", 0, 1, 1, 32'h10, 1, 32'h5, 1);
      idle("run_norm", 4);
      step("br_back", 0, 0, 0, 0, 1, 32'hFFFF_FFFD, 0);
      idle("br_flush", 2);
      idle("br_resume", 2);
      step("jmp_prio", 1, 0, 1, 32'h40, 1, 32'h7, 0);
      step("flush_br_ign", 0, 0, 0, 0, 1, 32'h9, 0);
      step("flush_jmp_ign", 0, 0, 1, 32'h80, 0, 0, 1);
      idle("run_after_jmp", 1);
      for (int i = 0; i < 3; i++) step("stall", 1, 0, 0, 0, 0, 0, 0);
      step("skip", 0, 0, 0, 0, 0, 0, 1);
      step("skip_stall", 1, 0, 0, 0, 0, 0, 1);
      step("jmp2", 0, 0, 1, 32'hDEAD_BEE0, 0, 0, 0);
      step("flush_stall", 1, 0, 0, 0, 0, 0, 0);
      idle("flush_end", 1);
      step("jmp3", 0, 0, 1, 32'h0000_1234, 0, 0, 0);
      idle("flush3", 2);
      step("br2", 0, 0, 0, 0, 1, 32'h0000_0010, 0);
      idle("flush4", 2);
      idle("run_pre_halt", 1);
      step("halt_prio", 1, 1, 1, 32'h55, 1, 32'h3, 1);
      for (int i = 0; i < 10; i++) step("halt_hold", 0, 0, 1, 32'h99, 1, 32'h1, 1);
      do_reset("reset_in_halt");
      step("boot2", 0, 0, 0, 0, 0, 0, 0);
      idle("run2", 2);
      step("br_then_halt", 0, 0, 0, 0, 1, 32'h8, 0);
      step("flush_halt", 0, 1, 0, 0, 0, 0, 0);
      step("halt2", 0, 0, 0, 0, 0, 0, 0);
      do_reset("reset_in_halt2");
      step("boot3", 0, 0, 0, 0, 0, 0, 0);
      step("br_only", 0, 0, 0, 0, 1, 32'h8000_0000, 0);
      do_reset("reset_mid_flush");
      step("boot4", 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 400; i++) begin
         if (m_state == 3 && $urandom_range(0, 3) == 0) begin
            do_reset("rnd_reset");
         end
         step("rnd", ($urandom_range(0, 4) == 0), ($urandom_range(0, 60) == 0),
              ($urandom_range(0, 7) == 0), $urandom, ($urandom_range(0, 6) == 0),
              $urandom, ($urandom_range(0, 5) == 0));
      end
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end
endmodule
